snake_move_ctrl: RTL and testbench

Game-step engine directly downstream of the snake clock divider. Samples the divider's slow `Snake_clk` level in the system clock domain and converts each rising edge into one movement step. On each step it advances the snake head on the grid, shifts the body segment registers, applies growth requests and detects wall and self collisions. Head, body, length and game state go to the VGA renderer and the food/score logic.

---
 rtl/snake_pkg.sv | 32 +++
 rtl/snake_collision_check.sv | 32 +++
 rtl/snake_move_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_snake_move_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared types and default constants for the snake game-step engine.
// Direction and state encodings plus a helper to find a reversal.
package snake_pkg;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    DOWN  = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DEAD = 2'd2
  } state_t;

  localparam int GRID_W_DEF  = 40;
  localparam int GRID_H_DEF  = 30;
  localparam int X_W_DEF     = 6;
  localparam int Y_W_DEF     = 5;
  localparam int MAX_LEN_DEF = 16;
  localparam int START_X_DEF = 20;
  localparam int START_Y_DEF = 15;
  localparam int INIT_LEN    = 3;

  // UP/DOWN and LEFT/RIGHT differ only in bit 0.
  function automatic dir_t dir_opp(input dir_t d);
    return dir_t'(d ^ 2'b01);
  endfunction

endpackage

// File: rtl/snake_collision_check.sv
// Combinational self-collision test of a candidate head against the body.
// Ports: cand_x/cand_y candidate, body_x/body_y packed segments (seg0 in LSBs),
//        length active count, chk_tail includes segment length-1, hit result.
module snake_collision_check #(
  parameter int MAX_LEN = 16,
  parameter int X_W     = 6,
  parameter int Y_W     = 5,
  parameter int LW      = 5
) (
  input  logic [X_W-1:0]         cand_x,
  input  logic [Y_W-1:0]         cand_y,
  input  logic [MAX_LEN*X_W-1:0] body_x,
  input  logic [MAX_LEN*Y_W-1:0] body_y,
  input  logic [LW-1:0]          length,
  input  logic                   chk_tail,
  output logic                   hit
);

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      // The tail only stays put when the snake is growing on this step.
      if ((i + 1 < int'(length)) ||
          (chk_tail && (i + 1 == int'(length)))) begin
        if (body_x[i*X_W +: X_W] == cand_x &&
            body_y[i*Y_W +: Y_W] == cand_y)
          hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/snake_move_ctrl.sv
// Snake game-step engine: turns Snake_clk rising edges into movement steps,
// shifts body segments, applies growth and detects wall/self collisions.
// Ports: clk, rst (sync, active-high), Snake_clk, btn_up/down/left/right,
//        start, grow -> head_x, head_y, body_x, body_y, length, dir, step,
//        running, dead.  Macro SNAKE_WRAP_EN: wrap at walls instead of dying.
module snake_move_ctrl
  import snake_pkg::*;
#(
  parameter int GRID_W  = GRID_W_DEF,
  parameter int GRID_H  = GRID_H_DEF,
  parameter int X_W     = X_W_DEF,
  parameter int Y_W     = Y_W_DEF,
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int START_X = START_X_DEF,
  parameter int START_Y = START_Y_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           Snake_clk,
  input  logic                           btn_up,
  input  logic                           btn_down,
  input  logic                           btn_left,
  input  logic                           btn_right,
  input  logic                           start,
  input  logic                           grow,
  output logic [X_W-1:0]                 head_x,
  output logic [Y_W-1:0]                 head_y,
  output logic [MAX_LEN*X_W-1:0]         body_x,
  output logic [MAX_LEN*Y_W-1:0]         body_y,
  output logic [$clog2(MAX_LEN+1)-1:0]   length,
  output logic [1:0]                     dir,
  output logic                           step,
  output logic                           running,
  output logic                           dead
);

  localparam int LW = $clog2(MAX_LEN+1);

  localparam logic [X_W-1:0] XMAX   = X_W'(GRID_W-1);
  localparam logic [Y_W-1:0] YMAX   = Y_W'(GRID_H-1);
  localparam logic [X_W:0]   XMAX_E = (X_W+1)'(GRID_W-1);
  localparam logic [Y_W:0]   YMAX_E = (Y_W+1)'(GRID_H-1);
  localparam logic [X_W:0]   X_ONE  = (X_W+1)'(1);
  localparam logic [Y_W:0]   Y_ONE  = (Y_W+1)'(1);
  localparam logic [LW-1:0]  LEN0   = LW'(INIT_LEN);
  localparam logic [LW-1:0]  LENMAX = LW'(MAX_LEN);

  state_t state_q, state_d;
  logic   prev_q;
  dir_t   dir_q, dir_d;
  dir_t   pend_q, pend_d;
  logic   gpend_q, gpend_d;
  logic   step_q, step_d;
  logic [LW-1:0] len_q, len_d;

  logic [MAX_LEN-1:0][X_W-1:0] seg_x_q, seg_x_d, init_x;
  logic [MAX_LEN-1:0][Y_W-1:0] seg_y_q, seg_y_d, init_y;

  logic tick;
  logic req_vld;
  dir_t req;
  logic grow_eff;

  logic [X_W:0]   nx;
  logic [Y_W:0]   ny;
  logic           x_oob, y_oob;
  logic           wall_hit, self_hit;
  logic [X_W-1:0] cand_x;
  logic [Y_W-1:0] cand_y;

  assign tick     = Snake_clk & ~prev_q;
  assign grow_eff = gpend_q | grow;

  always_comb begin
    init_x = '0;
    init_y = '0;
    for (int i = 0; i < INIT_LEN; i++) begin
      init_x[i] = X_W'(START_X - i);
      init_y[i] = Y_W'(START_Y);
    end
  end

  always_comb begin
    req_vld = btn_up | btn_down | btn_left | btn_right;
    req     = RIGHT;
    priority case (1'b1)
      btn_up:   req = UP;
      btn_down: req = DOWN;
      btn_left: req = LEFT;
      default:  req = RIGHT;
    endcase
  end

  // One spare bit so that 0-1 and MAX+1 both land out of range.
  always_comb begin
    nx = {1'b0, seg_x_q[0]};
    ny = {1'b0, seg_y_q[0]};
    unique case (pend_q)
      UP:      ny = ny - Y_ONE;
      DOWN:    ny = ny + Y_ONE;
      LEFT:    nx = nx - X_ONE;
      RIGHT:   nx = nx + X_ONE;
      default: ;
    endcase
    x_oob = nx > XMAX_E;
    y_oob = ny > YMAX_E;
`ifdef SNAKE_WRAP_EN
    wall_hit = 1'b0;
    cand_x = x_oob ? ((pend_q == LEFT) ? XMAX : '0)
                   : nx[X_W-1:0];
    cand_y = y_oob ? ((pend_q == UP) ? YMAX : '0)
                   : ny[Y_W-1:0];
`else
    wall_hit = x_oob | y_oob;
    cand_x = nx[X_W-1:0];
    cand_y = ny[Y_W-1:0];
`endif
  end

  snake_collision_check #(
    .MAX_LEN (MAX_LEN),
    .X_W     (X_W),
    .Y_W     (Y_W),
    .LW      (LW)
  ) u_coll (
    .cand_x   (cand_x),
    .cand_y   (cand_y),
    .body_x   (seg_x_q),
    .body_y   (seg_y_q),
    .length   (len_q),
    .chk_tail (grow_eff),
    .hit      (self_hit)
  );

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    pend_d  = pend_q;
    gpend_d = gpend_q;
    len_d   = len_q;
    seg_x_d = seg_x_q;
    seg_y_d = seg_y_q;
    step_d  = 1'b0;

    if (req_vld && req != dir_opp(dir_q))
      pend_d = req;
    if (grow)
      gpend_d = 1'b1;

    unique case (state_q)
      IDLE, DEAD: begin
        if (start) begin
          state_d = RUN;
          dir_d   = RIGHT;
          pend_d  = RIGHT;
          gpend_d = 1'b0;
          len_d   = LEN0;
          seg_x_d = init_x;
          seg_y_d = init_y;
        end
      end
      RUN: begin
        if (tick) begin
          if (wall_hit || self_hit) begin
            state_d = DEAD;
          end else begin
            for (int i = 1; i < MAX_LEN; i++) begin
              seg_x_d[i] = seg_x_q[i-1];
              seg_y_d[i] = seg_y_q[i-1];
            end
            seg_x_d[0] = cand_x;
            seg_y_d[0] = cand_y;
            dir_d   = pend_q;
            step_d  = 1'b1;
            gpend_d = 1'b0;
            if (grow_eff && len_q != LENMAX)
              len_d = len_q + LW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      prev_q  <= 1'b0;
      dir_q   <= RIGHT;
      pend_q  <= RIGHT;
      gpend_q <= 1'b0;
      step_q  <= 1'b0;
      len_q   <= LEN0;
      seg_x_q <= init_x;
      seg_y_q <= init_y;
    end else begin
      state_q <= state_d;
      prev_q  <= Snake_clk;
      dir_q   <= dir_d;
      pend_q  <= pend_d;
      gpend_q <= gpend_d;
      step_q  <= step_d;
      len_q   <= len_d;
      seg_x_q <= seg_x_d;
      seg_y_q <= seg_y_d;
    end
  end

  assign head_x  = seg_x_q[0];
  assign head_y  = seg_y_q[0];
  assign body_x  = seg_x_q;
  assign body_y  = seg_y_q;
  assign length  = len_q;
  assign dir     = dir_q;
  assign step    = step_q;
  assign running = (state_q == RUN);
  assign dead    = (state_q == DEAD);

endmodule

// File: tb/tb_snake_move_ctrl.sv
// Directed self-checking bench for snake_move_ctrl.
// Table of per-tick vectors plus hand sequences for restart, growth and walls.
module tb_snake_move_ctrl;

  localparam int X_W     = 6;
  localparam int Y_W     = 5;
  localparam int MAX_LEN = 16;
  localparam int LW      = 5;

  logic clk = 1'b0;
  logic rst, Snake_clk;
  logic bu, bd, bl, br;
  logic start, grow;

  logic [X_W-1:0]         head_x;
  logic [Y_W-1:0]         head_y;
  logic [MAX_LEN*X_W-1:0] body_x;
  logic [MAX_LEN*Y_W-1:0] body_y;
  logic [LW-1:0]          length;
  logic [1:0]             dir;
  logic                   step, running, dead;

  snake_move_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .Snake_clk (Snake_clk),
    .btn_up    (bu),
    .btn_down  (bd),
    .btn_left  (bl),
    .btn_right (br),
    .start     (start),
    .grow      (grow),
    .head_x    (head_x),
    .head_y    (head_y),
    .body_x    (body_x),
    .body_y    (body_y),
    .length    (length),
    .dir       (dir),
    .step      (step),
    .running   (running),
    .dead      (dead)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int steps  = 0;

  always @(negedge clk) if (step) steps = steps + 1;

  typedef struct {
    logic [3:0] btn;
    logic       g;
    int hx, hy, len, d, tx, ty, dd, nstep;
  } vec_t;

  vec_t v[11];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick_with(input logic [3:0] b, input logic g);
    @(negedge clk);
    {bu, bd, bl, br} = b;
    grow = g;
    @(negedge clk);
    Snake_clk = 1'b1;
    @(negedge clk);
    Snake_clk = 1'b0;
    {bu, bd, bl, br} = 4'b0;
    grow = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic chk_init(input string tag);
    chk({tag, " running"}, int'(running), 0);
    chk({tag, " dead"}, int'(dead), 0);
    chk({tag, " step"}, int'(step), 0);
    chk({tag, " head_x"}, int'(head_x), 20);
    chk({tag, " head_y"}, int'(head_y), 15);
    chk({tag, " length"}, int'(length), 3);
    chk({tag, " dir"}, int'(dir), 3);
  endtask

  int s0;

  initial begin
    v[0]  = '{4'b0000, 1'b0, 21, 15, 3, 3, 19, 15, 0, 1};
    v[1]  = '{4'b0000, 1'b0, 22, 15, 3, 3, 20, 15, 0, 1};
    v[2]  = '{4'b0000, 1'b0, 23, 15, 3, 3, 21, 15, 0, 1};
    v[3]  = '{4'b0010, 1'b0, 24, 15, 3, 3, 22, 15, 0, 1};
    v[4]  = '{4'b0010, 1'b0, 25, 15, 3, 3, 23, 15, 0, 1};
    v[5]  = '{4'b0000, 1'b1, 26, 15, 4, 3, 23, 15, 0, 1};
    v[6]  = '{4'b0000, 1'b1, 27, 15, 5, 3, 23, 15, 0, 1};
    v[7]  = '{4'b0100, 1'b0, 27, 16, 5, 1, 24, 15, 0, 1};
    v[8]  = '{4'b0010, 1'b0, 26, 16, 5, 2, 25, 15, 0, 1};
    v[9]  = '{4'b1000, 1'b0, 26, 16, 5, 2, 25, 15, 1, 0};
    v[10] = '{4'b0000, 1'b0, 26, 16, 5, 2, 25, 15, 1, 0};

    rst = 1'b1;
    Snake_clk = 1'b0;
    {bu, bd, bl, br} = 4'b0;
    start = 1'b0;
    grow = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst step", int'(step), 0);
    chk("rst running", int'(running), 0);
    rst = 1'b0;
    @(negedge clk);
    chk_init("reset");
    chk("reset seg1_x", int'(body_x[1*X_W +: X_W]), 19);
    chk("reset seg2_x", int'(body_x[2*X_W +: X_W]), 18);
    chk("reset seg3_x", int'(body_x[3*X_W +: X_W]), 0);

    s0 = steps;
    tick_with(4'b0000, 1'b0);
    chk("idle tick head_x", int'(head_x), 20);
    chk("idle tick steps", steps - s0, 0);

    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start running", int'(running), 1);

    for (int i = 0; i < 11; i++) begin
      s0 = steps;
      tick_with(v[i].btn, v[i].g);
      chk($sformatf("v%0d head_x", i), int'(head_x), v[i].hx);
      chk($sformatf("v%0d head_y", i), int'(head_y), v[i].hy);
      chk($sformatf("v%0d length", i), int'(length), v[i].len);
      chk($sformatf("v%0d dir", i), int'(dir), v[i].d);
      chk($sformatf("v%0d tail_x", i),
          int'(body_x[(v[i].len-1)*X_W +: X_W]), v[i].tx);
      chk($sformatf("v%0d tail_y", i),
          int'(body_y[(v[i].len-1)*Y_W +: Y_W]), v[i].ty);
      chk($sformatf("v%0d dead", i), int'(dead), v[i].dd);
      chk($sformatf("v%0d steps", i), steps - s0, v[i].nstep);
    end

    // Restart from DEAD with a tick on the same edge: tick is dropped.
    s0 = steps;
    @(negedge clk);
    start = 1'b1;
    Snake_clk = 1'b1;
    @(negedge clk);
    start = 1'b0;
    Snake_clk = 1'b0;
    @(negedge clk);
    chk("restart running", int'(running), 1);
    chk("restart dead", int'(dead), 0);
    chk("restart head_x", int'(head_x), 20);
    chk("restart head_y", int'(head_y), 15);
    chk("restart length", int'(length), 3);
    chk("restart steps", steps - s0, 0);

    // Twenty grows along an L path: length saturates at 16.
    s0 = steps;
    for (int k = 0; k < 20; k++)
      tick_with((k < 10) ? 4'b0000 : 4'b0100, 1'b1);
    chk("sat length", int'(length), 16);
    chk("sat head_x", int'(head_x), 30);
    chk("sat head_y", int'(head_y), 25);
    chk("sat dir", int'(dir), 1);
    chk("sat steps", steps - s0, 20);

    for (int k = 0; k < 9; k++)
      tick_with(4'b0001, 1'b0);
    chk("edge head_x", int'(head_x), 39);
    chk("edge dead", int'(dead), 0);

    s0 = steps;
    tick_with(4'b0001, 1'b0);
`ifdef SNAKE_WRAP_EN
    chk("wall head_x", int'(head_x), 0);
    chk("wall dead", int'(dead), 0);
    chk("wall steps", steps - s0, 1);
`else
    chk("wall head_x", int'(head_x), 39);
    chk("wall dead", int'(dead), 1);
    chk("wall steps", steps - s0, 0);
`endif
    chk("wall head_y", int'(head_y), 25);
    chk("wall length", int'(length), 16);

    // Reset mid-game with pending grow and direction.
    @(negedge clk);
    grow = 1'b1;
    bu = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    grow = 1'b0;
    bu = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_init("midrst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
